// File: rtl/cnn_layer_sequencer.sv
// Layer-level scheduler for the CNN engine array: walks up to NUM_LAYERS layers and pulses each
// enabled engine (conv|fc, relu, maxp, sfmax) in turn. Define CNN_SEQ_TIMEOUT_EN for a per-stage watchdog.
module cnn_layer_sequencer #(
   parameter int unsigned NUM_LAYERS     = 32,
   parameter int unsigned LAYER_W        = 6,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LAYER_W-1:0]    num_layers,
   input  logic [NUM_LAYERS-1:0] conv_en,
   input  logic [NUM_LAYERS-1:0] relu_en,
   input  logic [NUM_LAYERS-1:0] maxp_en,
   input  logic [NUM_LAYERS-1:0] fc_en,
   input  logic [NUM_LAYERS-1:0] sfmax_en,
   input  logic                  conv_done,
   input  logic                  relu_done,
   input  logic                  maxp_done,
   input  logic                  fc_done,
   input  logic                  sfmax_done,
   output logic                  conv_start,
   output logic                  relu_start,
   output logic                  maxp_start,
   output logic                  fc_start,
   output logic                  sfmax_start,
   output logic                  busy,
   output logic                  run_done,
   output logic [LAYER_W-1:0]    layer_idx,
   output logic                  buf_sel,
   output logic                  cfg_err,
   output logic                  timeout_err
);

   localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   if (((32'd1 << LAYER_W) <= NUM_LAYERS) || (TIMEOUT_CYCLES == 0)) begin : g_param_check
      $error("cnn_layer_sequencer: LAYER_W too narrow for NUM_LAYERS or TIMEOUT_CYCLES is zero");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_CONV,
      S_FC,
      S_RELU,
      S_MAXP,
      S_SFMAX,
      S_NEXT
   } state_e;

   state_e                state_q, state_d;
   logic [NUM_LAYERS-1:0] conv_en_q, conv_en_d;
   logic [NUM_LAYERS-1:0] relu_en_q, relu_en_d;
   logic [NUM_LAYERS-1:0] maxp_en_q, maxp_en_d;
   logic [NUM_LAYERS-1:0] fc_en_q, fc_en_d;
   logic [NUM_LAYERS-1:0] sfmax_en_q, sfmax_en_d;
   logic [LAYER_W-1:0]    num_q, num_d;
   logic [LAYER_W-1:0]    layer_idx_q, layer_idx_d;
   logic                  busy_q, busy_d;
   logic                  run_done_q, run_done_d;
   logic                  buf_sel_q, buf_sel_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  conv_start_q, conv_start_d;
   logic                  relu_start_q, relu_start_d;
   logic                  maxp_start_q, maxp_start_d;
   logic                  fc_start_q, fc_start_d;
   logic                  sfmax_start_q, sfmax_start_d;

   logic [IDX_W-1:0]      lidx;
   logic                  l_conv, l_relu, l_maxp, l_fc, l_sfmax;
   logic                  done_hit;

`ifdef CNN_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  timeout_err_q, timeout_err_d;
   logic                  in_stage;
   logic                  tmo_hit;
`endif

   // First enabled stage at or after position 'from' (0: conv|fc, 1: relu, 2: maxp, 3: sfmax)
   function automatic state_e pick_stage(input logic [1:0] from, input logic cv, input logic fcv,
                                         input logic rl, input logic mp, input logic sm);
      state_e nxt;
      nxt = S_NEXT;
      if ((from == 2'd0) && (cv || fcv)) nxt = cv ? S_CONV : S_FC;
      else if ((from <= 2'd1) && rl)     nxt = S_RELU;
      else if ((from <= 2'd2) && mp)     nxt = S_MAXP;
      else if (sm)                       nxt = S_SFMAX;
      return nxt;
   endfunction

   assign lidx    = IDX_W'(layer_idx_q);
   assign l_conv  = conv_en_q[lidx];
   assign l_relu  = relu_en_q[lidx];
   assign l_maxp  = maxp_en_q[lidx];
   assign l_fc    = fc_en_q[lidx];
   assign l_sfmax = sfmax_en_q[lidx];

`ifdef CNN_SEQ_TIMEOUT_EN
   assign in_stage = (state_q == S_CONV) || (state_q == S_FC) || (state_q == S_RELU) ||
                     (state_q == S_MAXP) || (state_q == S_SFMAX);
   assign tmo_hit  = in_stage && !done_hit && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state, capture and output logic
   always_comb begin
      state_d     = state_q;
      conv_en_d   = conv_en_q;
      relu_en_d   = relu_en_q;
      maxp_en_d   = maxp_en_q;
      fc_en_d     = fc_en_q;
      sfmax_en_d  = sfmax_en_q;
      num_d       = num_q;
      layer_idx_d = layer_idx_q;
      busy_d      = busy_q;
      run_done_d  = 1'b0;
      buf_sel_d   = buf_sel_q;
      cfg_err_d   = cfg_err_q;
      done_hit    = 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               conv_en_d   = conv_en;
               relu_en_d   = relu_en;
               maxp_en_d   = maxp_en;
               fc_en_d     = fc_en;
               sfmax_en_d  = sfmax_en;
               num_d       = (num_layers > LAYER_W'(NUM_LAYERS)) ? LAYER_W'(NUM_LAYERS) : num_layers;
               cfg_err_d   = (num_layers > LAYER_W'(NUM_LAYERS));
               layer_idx_d = '0;
               buf_sel_d   = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_DISPATCH;
`ifdef CNN_SEQ_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end
         end
         S_DISPATCH: begin
            if (num_q == '0) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               run_done_d = 1'b1;
            end else begin
               state_d = pick_stage(2'd0, l_conv, l_fc, l_relu, l_maxp, l_sfmax);
               if (l_conv && l_fc) cfg_err_d = 1'b1;
            end
         end
         S_CONV: begin
            done_hit = conv_done && !conv_start_q;
            if (done_hit) state_d = pick_stage(2'd1, l_conv, l_fc, l_relu, l_maxp, l_sfmax);
         end
         S_FC: begin
            done_hit = fc_done && !fc_start_q;
            if (done_hit) state_d = pick_stage(2'd1, l_conv, l_fc, l_relu, l_maxp, l_sfmax);
         end
         S_RELU: begin
            done_hit = relu_done && !relu_start_q;
            if (done_hit) state_d = pick_stage(2'd2, l_conv, l_fc, l_relu, l_maxp, l_sfmax);
         end
         S_MAXP: begin
            done_hit = maxp_done && !maxp_start_q;
            if (done_hit) state_d = pick_stage(2'd3, l_conv, l_fc, l_relu, l_maxp, l_sfmax);
         end
         S_SFMAX: begin
            done_hit = sfmax_done && !sfmax_start_q;
            if (done_hit) state_d = S_NEXT;
         end
         S_NEXT: begin
            layer_idx_d = layer_idx_q + LAYER_W'(1);
            buf_sel_d   = ~buf_sel_q;
            if ((layer_idx_q + LAYER_W'(1)) == num_q) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               run_done_d = 1'b1;
            end else begin
               state_d = S_DISPATCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef CNN_SEQ_TIMEOUT_EN
      if (tmo_hit) begin
         state_d       = S_IDLE;
         busy_d        = 1'b0;
         timeout_err_d = 1'b1;
      end
`endif

      // Abort wins over done/timeout; progress registers hold their pre-abort values
      if (abort && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         busy_d      = 1'b0;
         run_done_d  = 1'b0;
         layer_idx_d = layer_idx_q;
         buf_sel_d   = buf_sel_q;
      end

      conv_start_d  = (state_d == S_CONV)  && (state_q != S_CONV);
      relu_start_d  = (state_d == S_RELU)  && (state_q != S_RELU);
      maxp_start_d  = (state_d == S_MAXP)  && (state_q != S_MAXP);
      fc_start_d    = (state_d == S_FC)    && (state_q != S_FC);
      sfmax_start_d = (state_d == S_SFMAX) && (state_q != S_SFMAX);
   end

`ifdef CNN_SEQ_TIMEOUT_EN
   // Watchdog restarts on every stage entry
   always_comb begin
      cnt_d = '0;
      if (in_stage && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         conv_en_q     <= '0;
         relu_en_q     <= '0;
         maxp_en_q     <= '0;
         fc_en_q       <= '0;
         sfmax_en_q    <= '0;
         num_q         <= '0;
         layer_idx_q   <= '0;
         busy_q        <= 1'b0;
         run_done_q    <= 1'b0;
         buf_sel_q     <= 1'b0;
         cfg_err_q     <= 1'b0;
         conv_start_q  <= 1'b0;
         relu_start_q  <= 1'b0;
         maxp_start_q  <= 1'b0;
         fc_start_q    <= 1'b0;
         sfmax_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         conv_en_q     <= conv_en_d;
         relu_en_q     <= relu_en_d;
         maxp_en_q     <= maxp_en_d;
         fc_en_q       <= fc_en_d;
         sfmax_en_q    <= sfmax_en_d;
         num_q         <= num_d;
         layer_idx_q   <= layer_idx_d;
         busy_q        <= busy_d;
         run_done_q    <= run_done_d;
         buf_sel_q     <= buf_sel_d;
         cfg_err_q     <= cfg_err_d;
         conv_start_q  <= conv_start_d;
         relu_start_q  <= relu_start_d;
         maxp_start_q  <= maxp_start_d;
         fc_start_q    <= fc_start_d;
         sfmax_start_q <= sfmax_start_d;
      end
   end

   assign conv_start  = conv_start_q;
   assign relu_start  = relu_start_q;
   assign maxp_start  = maxp_start_q;
   assign fc_start    = fc_start_q;
   assign sfmax_start = sfmax_start_q;
   assign busy        = busy_q;
   assign run_done    = run_done_q;
   assign layer_idx   = layer_idx_q;
   assign buf_sel     = buf_sel_q;
   assign cfg_err     = cfg_err_q;

endmodule
